// File: rtl/steer_arbiter.sv
// steer_arbiter: fixed-priority steering arbiter with per-position dwell,
// ladder slewing and idle return-to-straight.
// Optional feature macro: STEER_SLEW_EN. When it is defined, the wheels move
// one ladder position per dwell. When it is undefined, they jump straight to
// the target.
module steer_arbiter #(
    parameter int unsigned MIN_HOLD_US     = 20000,
    parameter int unsigned IDLE_TIMEOUT_US = 500000
) (
    input  logic       clkus,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] dir_avoid,
    input  logic [2:0] dir_remote,
    input  logic [2:0] dir_track,
    output logic [2:0] direction,
    output logic [2:0] grant,
    output logic       settled
);

    localparam logic [2:0]  Straight  = 3'b000;
    localparam logic [15:0] HoldLoad  = 16'(MIN_HOLD_US - 1);
    localparam logic [19:0] IdleLimit = 20'(IDLE_TIMEOUT_US);

    typedef enum logic {StSettled, StMoving} state_e;

    state_e      state_q, state_d;
    logic [2:0]  dir_q, dir_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  target_q, target_d;
    logic [19:0] idle_q, idle_d;
    logic [15:0] hold_q, hold_d;
    logic [2:0]  step_dir;

    // Illegal codes (010, 100, 110) collapse to straight.
    function automatic logic [2:0] norm_code(input logic [2:0] c);
        case (c)
            3'b001, 3'b011, 3'b101, 3'b111: norm_code = c;
            default:                        norm_code = Straight;
        endcase
    endfunction

`ifdef STEER_SLEW_EN
    // Ladder index: LEFT_BIG=0 ... RIGHT_BIG=4.
    function automatic logic [2:0] ladder_pos(input logic [2:0] c);
        case (c)
            3'b011:  ladder_pos = 3'd0;
            3'b001:  ladder_pos = 3'd1;
            3'b101:  ladder_pos = 3'd3;
            3'b111:  ladder_pos = 3'd4;
            default: ladder_pos = 3'd2;
        endcase
    endfunction

    function automatic logic [2:0] ladder_code(input logic [2:0] p);
        case (p)
            3'd0:    ladder_code = 3'b011;
            3'd1:    ladder_code = 3'b001;
            3'd3:    ladder_code = 3'b101;
            3'd4:    ladder_code = 3'b111;
            default: ladder_code = Straight;
        endcase
    endfunction

    // One ladder position toward the target.
    always_comb begin
        step_dir = dir_q;
        if (ladder_pos(target_q) > ladder_pos(dir_q)) begin
            step_dir = ladder_code(ladder_pos(dir_q) + 3'd1);
        end else if (ladder_pos(target_q) < ladder_pos(dir_q)) begin
            step_dir = ladder_code(ladder_pos(dir_q) - 3'd1);
        end
    end
`else
    // Jump directly to the target.
    always_comb begin
        step_dir = target_q;
    end
`endif

    // Fixed-priority arbitration and the idle return-to-straight timer.
    always_comb begin
        grant_d  = 3'b000;
        target_d = target_q;
        idle_d   = (idle_q == IdleLimit) ? idle_q : idle_q + 20'd1;
        if (req[2]) begin
            grant_d  = 3'b100;
            target_d = norm_code(dir_avoid);
        end else if (req[1]) begin
            grant_d  = 3'b010;
            target_d = norm_code(dir_remote);
        end else if (req[0]) begin
            grant_d  = 3'b001;
            target_d = norm_code(dir_track);
        end
        if (req != 3'b000) begin
            idle_d = '0;
        end else if (idle_d == IdleLimit) begin
            target_d = Straight;
        end
    end

    // Dwell/step FSM: a new position may only be taken once the hold expires.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hold_d  = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;
        case (state_q)
            StSettled: begin
                if (target_q != dir_q) begin
                    dir_d   = step_dir;
                    hold_d  = HoldLoad;
                    state_d = StMoving;
                end
            end
            StMoving: begin
                if (hold_q == 16'd0) begin
                    if (target_q != dir_q) begin
                        dir_d  = step_dir;
                        hold_d = HoldLoad;
                    end else begin
                        state_d = StSettled;
                    end
                end
            end
            default: state_d = StSettled;
        endcase
    end

    // State registers; reset snaps the wheels straight with no dwell.
    always_ff @(posedge clkus or negedge rst) begin
        if (!rst) begin
            state_q  <= StSettled;
            dir_q    <= Straight;
            grant_q  <= 3'b000;
            target_q <= Straight;
            idle_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            grant_q  <= grant_d;
            target_q <= target_d;
            idle_q   <= idle_d;
            hold_q   <= hold_d;
        end
    end

    assign direction = dir_q;
    assign grant     = grant_q;
    assign settled   = (state_q == StSettled);

endmodule
